sad_search_ctrl: RTL and testbench

- Sequential scheduler for motion-estimation search on a 64x64 frame with a 4x4 window.
- Replaces the fully parallel SAD array with one shared, pipelined SAD engine.
- Issues every candidate window position (i,j) to the engine in raster order, collects the returned SADs in order, and tracks the running minimum.
- Reports MinI/MinJ/MinVal with a Done pulse.

---
 rtl/sad_search_ctrl_if.sv | 28 ++
 rtl/sad_search_ctrl.sv | 147 ++++++++++++++
 tb/tb_sad_search_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sad_search_ctrl_if.sv
// rtl/sad_search_ctrl_if.sv - start/result, candidate request and SAD response signals of sad_search_ctrl
interface sad_search_ctrl_if #(
  parameter int IDX_W = 6,
  parameter int SAD_W = 12
);
  logic             Start;
  logic             Busy;
  logic             Done;
  logic             ReqValid;
  logic             ReqReady;
  logic [IDX_W-1:0] ReqI;
  logic [IDX_W-1:0] ReqJ;
  logic             RspValid;
  logic [SAD_W-1:0] RspSAD;
  logic [IDX_W-1:0] MinI;
  logic [IDX_W-1:0] MinJ;
  logic [SAD_W-1:0] MinVal;

  modport master (
    input  Start, ReqReady, RspValid, RspSAD,
    output Busy, Done, ReqValid, ReqI, ReqJ, MinI, MinJ, MinVal
  );

  modport slave (
    output Start, ReqReady, RspValid, RspSAD,
    input  Busy, Done, ReqValid, ReqI, ReqJ, MinI, MinJ, MinVal
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - raster scheduler feeding one shared SAD engine and tracking the minimum SAD
module sad_search_ctrl #(
  parameter int FRAME_DIM = 64,
  parameter int WIN_DIM   = 4,
  parameter int IDX_W     = 6,
  parameter int SAD_W     = 12,
  parameter int MAX_OUT   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  sad_search_ctrl_if.master ctrl
);
  localparam int LAST  = FRAME_DIM - WIN_DIM;
  localparam int TOTAL = (LAST + 1) * (LAST + 1);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] TOTAL_M1  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [IDX_W-1:0] LAST_C    = IDX_W'(LAST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] iss_i_q, iss_i_d, iss_j_q, iss_j_d;
  logic [IDX_W-1:0] rsp_i_q, rsp_i_d, rsp_j_q, rsp_j_d;
  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic             first_q, first_d;
  logic [IDX_W-1:0] min_i_q, min_i_d, min_j_q, min_j_d;
  logic [SAD_W-1:0] min_val_q, min_val_d;

  logic [CNT_W-1:0] outstanding;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_take;

  // Outstanding uses registered counts only, so a response never frees a slot in its own cycle
  assign outstanding = iss_cnt_q - rsp_cnt_q;
  assign req_valid   = (state_q == S_ISSUE) && (iss_cnt_q < TOTAL_C) && (outstanding < MAX_OUT_C);
  assign req_fire    = req_valid && ctrl.ReqReady;
  assign rsp_take    = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && ctrl.RspValid
                       && (rsp_cnt_q < TOTAL_C);

  always_comb begin
    state_d   = state_q;
    iss_i_d   = iss_i_q;
    iss_j_d   = iss_j_q;
    rsp_i_d   = rsp_i_q;
    rsp_j_d   = rsp_j_q;
    iss_cnt_d = iss_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    first_d   = first_q;
    min_i_d   = min_i_q;
    min_j_d   = min_j_q;
    min_val_d = min_val_q;

    if (rsp_take) begin
      rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
      first_d   = 1'b0;
      // Strict less-than keeps the earliest raster position on ties
      if (first_q || (ctrl.RspSAD < min_val_q)) begin
        min_val_d = ctrl.RspSAD;
        min_i_d   = rsp_i_q;
        min_j_d   = rsp_j_q;
      end
      if (rsp_j_q == LAST_C) begin
        rsp_j_d = '0;
        if (rsp_i_q != LAST_C) rsp_i_d = rsp_i_q + IDX_W'(1);
      end else begin
        rsp_j_d = rsp_j_q + IDX_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl.Start) begin
          state_d   = S_ISSUE;
          iss_i_d   = '0;
          iss_j_d   = '0;
          rsp_i_d   = '0;
          rsp_j_d   = '0;
          iss_cnt_d = '0;
          rsp_cnt_d = '0;
          first_d   = 1'b1;
          min_i_d   = '0;
          min_j_d   = '0;
          min_val_d = '1;
        end
      end
      S_ISSUE: begin
        if (req_fire) begin
          iss_cnt_d = iss_cnt_q + CNT_W'(1);
          // The pointer parks on the last candidate instead of stepping past it
          if (iss_cnt_q == TOTAL_M1) begin
            state_d = S_DRAIN;
          end else if (iss_j_q == LAST_C) begin
            iss_j_d = '0;
            iss_i_d = iss_i_q + IDX_W'(1);
          end else begin
            iss_j_d = iss_j_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (rsp_take && (rsp_cnt_q == TOTAL_M1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      iss_i_q   <= '0;
      iss_j_q   <= '0;
      rsp_i_q   <= '0;
      rsp_j_q   <= '0;
      iss_cnt_q <= '0;
      rsp_cnt_q <= '0;
      first_q   <= 1'b0;
      min_i_q   <= '0;
      min_j_q   <= '0;
      min_val_q <= '0;
    end else begin
      state_q   <= state_d;
      iss_i_q   <= iss_i_d;
      iss_j_q   <= iss_j_d;
      rsp_i_q   <= rsp_i_d;
      rsp_j_q   <= rsp_j_d;
      iss_cnt_q <= iss_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      first_q   <= first_d;
      min_i_q   <= min_i_d;
      min_j_q   <= min_j_d;
      min_val_q <= min_val_d;
    end
  end

  assign ctrl.Busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign ctrl.Done     = (state_q == S_DONE);
  assign ctrl.ReqValid = req_valid;
  assign ctrl.ReqI     = iss_i_q;
  assign ctrl.ReqJ     = iss_j_q;
  assign ctrl.MinI     = min_i_q;
  assign ctrl.MinJ     = min_j_q;
  assign ctrl.MinVal   = min_val_q;
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - randomized bench for sad_search_ctrl against a table-driven search model
module tb_sad_search_ctrl;
  localparam int N       = 61;
  localparam int TOTAL   = N * N;
  localparam int MAX_OUT = 8;
  localparam int BUDGET  = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sad_tab[TOTAL];

  always #5 clk = ~clk;

  sad_search_ctrl_if #(.IDX_W(6), .SAD_W(12)) bif ();

  sad_search_ctrl #(
    .FRAME_DIM(64), .WIN_DIM(4), .IDX_W(6), .SAD_W(12), .MAX_OUT(MAX_OUT)
  ) dut (
    .Clk  (clk),
    .Rst  (rst),
    .ctrl (bif)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [63:0] outs_vec();
    return {25'd0, bif.Busy, bif.Done, bif.ReqValid, bif.ReqI, bif.ReqJ,
            bif.MinI, bif.MinJ, bif.MinVal};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset_state", outs_vec(), 64'd0);
  endtask

  task automatic fill_tab(input int v);
    for (int n = 0; n < TOTAL; n++) sad_tab[n] = v;
  endtask

  task automatic fill_rand();
    for (int n = 0; n < TOTAL; n++) sad_tab[n] = int'($urandom_range(0, 4095));
  endtask

  task automatic run_search(input int lat, input int rmode, input bit hold, input int rst_at);
    int minv, mk, hs, rsp, p;
    int due_q[$];
    int pos_q[$];
    bit hs_now, rsp_now, fin;
    // Expected answer: smallest value, then its first raster position
    minv = 4096;
    mk   = 0;
    for (int n = 0; n < TOTAL; n++) if (sad_tab[n] < minv) minv = sad_tab[n];
    for (int n = TOTAL - 1; n >= 0; n--) if (sad_tab[n] == minv) mk = n;
    hs = 0; rsp = 0; hs_now = 0; rsp_now = 0; fin = 0;
    bif.Start = 1'b1;
    @(negedge clk);
    bif.Start = hold;
    check_eq("busy_after_start", 64'(bif.Busy), 64'd1);
    for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
      if (hs_now) hs++;
      if (rsp_now) rsp++;
      if (rst_at > 0 && hs >= rst_at) begin
        rst = 1'b1;
        bif.ReqReady = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_outputs", outs_vec(), 64'd0);
        for (int s = 0; s < 24; s++) begin
          if (pos_q.size() > 0) begin
            p = pos_q.pop_front();
            void'(due_q.pop_front());
            bif.RspValid = 1'b1;
            bif.RspSAD   = 12'(sad_tab[p]);
          end else begin
            bif.RspValid = 1'b0;
          end
          @(negedge clk);
          check_eq("stale_ignored", outs_vec(), 64'd0);
        end
        bif.RspValid = 1'b0;
        bif.Start    = 1'b0;
        return;
      end
      if (bif.Done) begin
        fin = 1;
        check_eq("busy_in_done", 64'(bif.Busy), 64'd0);
        check_eq("hs_total", 64'(hs), 64'(TOTAL));
        check_eq("rsp_at_done", 64'(rsp), 64'(TOTAL));
        check_eq("min_i", 64'(bif.MinI), 64'(mk / N));
        check_eq("min_j", 64'(bif.MinJ), 64'(mk % N));
        check_eq("min_val", 64'(bif.MinVal), 64'(minv));
        bif.ReqReady = 1'b0;
        bif.RspValid = 1'b0;
      end else begin
        check_eq("busy", 64'(bif.Busy), 64'd1);
        check_eq("req_valid", 64'(bif.ReqValid), 64'((hs < TOTAL) && (hs - rsp < MAX_OUT)));
        if (bif.ReqValid)
          check_eq("req_pos", 64'({bif.ReqI, bif.ReqJ}), 64'({6'(hs / N), 6'(hs % N)}));
        case (rmode)
          0:       bif.ReqReady = 1'b1;
          1:       bif.ReqReady = (cyc % 2 == 0);
          default: bif.ReqReady = 1'($urandom_range(0, 1));
        endcase
        hs_now = bif.ReqValid && bif.ReqReady;
        if (hs_now) begin
          due_q.push_back(cyc + lat);
          pos_q.push_back(hs);
        end
        rsp_now = 0;
        bif.RspValid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          p = pos_q.pop_front();
          void'(due_q.pop_front());
          bif.RspValid = 1'b1;
          bif.RspSAD   = 12'(sad_tab[p]);
          rsp_now = 1;
        end
        @(negedge clk);
      end
    end
    if (!fin) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      bif.Start = 1'b0;
      apply_reset();
      return;
    end
    @(negedge clk);
    check_eq("done_pulse", 64'(bif.Done), 64'd0);
    check_eq("idle_busy", 64'(bif.Busy), 64'd0);
    check_eq("min_hold", 64'(bif.MinVal), 64'(minv));
    if (hold) begin
      @(negedge clk);
      check_eq("restart_idle", 64'(bif.Busy), 64'd1);
      bif.Start = 1'b0;
      apply_reset();
    end
  endtask

  initial begin
    bif.Start    = 1'b0;
    bif.ReqReady = 1'b0;
    bif.RspValid = 1'b0;
    bif.RspSAD   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_state", outs_vec(), 64'd0);

    fill_tab(100);
    run_search(3, 0, 1'b0, 0);

    fill_tab(500);
    sad_tab[37 * N + 12] = 7;
    run_search(3, 0, 1'b0, 0);

    fill_tab(4095);
    sad_tab[5 * N + 5]  = 3;
    sad_tab[40 * N + 2] = 3;
    run_search(2, 0, 1'b0, 0);

    fill_tab(4095);
    run_search(2, 0, 1'b0, 0);

    fill_rand();
    run_search(20, 1, 1'b0, 0);

    fill_rand();
    run_search(4, 0, 1'b0, 1000);
    run_search(5, 0, 1'b0, 0);

    fill_rand();
    run_search(3, 0, 1'b1, 0);

    for (int r = 0; r < 2; r++) begin
      fill_rand();
      run_search(int'($urandom_range(1, 10)), 2, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
